// File: rtl/serial_subtractor_16_bit_if.sv
// Handshake bundle for the bit-serial subtractor: operand channel in, result channel out.
// With SERIAL_SUB_SIGNED_OVF_EN defined the result channel also carries the signed overflow flag.
interface serial_subtractor_16_bit_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] D;
    logic             Bout;
    logic             zero;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic             ovf;

    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, D, Bout, zero, ovf
    );
    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, D, Bout, zero, ovf
    );
`else
    modport master (
        output in_valid, A, B, out_ready,
        input  in_ready, out_valid, D, Bout, zero
    );
    modport slave (
        input  in_valid, A, B, out_ready,
        output in_ready, out_valid, D, Bout, zero
    );
`endif
endinterface

// File: rtl/serial_subtractor_16_bit.sv
// Bit-serial D = A - B (LSB first) using one full-adder slice on A + ~B + 1.
// Define SERIAL_SUB_SIGNED_OVF_EN to add the registered signed-overflow output ovf.
module serial_subtractor_16_bit #(
    parameter int unsigned WIDTH = 16
) (
    input logic                      clk,
    input logic                      rst,
    serial_subtractor_16_bit_if.slave bus
);
    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e           state_q;
    logic [CntW-1:0]  cnt_q;
    logic             carry_q;
    logic [WIDTH-1:0] a_sh_q;
    logic [WIDTH-1:0] b_sh_q;
    logic [WIDTH-1:0] res_q;
    logic [WIDTH-1:0] d_q;
    logic             out_valid_q;
    logic             bout_q;
    logic             zero_q;

    logic             sum;
    logic             carry_nxt;
    logic [WIDTH-1:0] res_nxt;

    always_comb begin
        sum       = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        carry_nxt = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);
        res_nxt   = {sum, res_q[WIDTH-1:1]};
    end

`ifdef SERIAL_SUB_SIGNED_OVF_EN
    logic ovf_q;

    // On the last RUN edge carry_q is the carry into the MSB slice.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (state_q == StRun && cnt_q == CntLast) begin
            ovf_q <= carry_q ^ carry_nxt;
        end
    end

    assign bus.ovf = ovf_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            carry_q     <= 1'b0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            res_q       <= '0;
            d_q         <= '0;
            out_valid_q <= 1'b0;
            bout_q      <= 1'b0;
            zero_q      <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        a_sh_q  <= bus.A;
                        b_sh_q  <= ~bus.B;
                        carry_q <= 1'b1;
                        cnt_q   <= '0;
                        state_q <= StRun;
                    end
                end
                StRun: begin
                    carry_q <= carry_nxt;
                    a_sh_q  <= a_sh_q >> 1;
                    b_sh_q  <= b_sh_q >> 1;
                    res_q   <= res_nxt;
                    cnt_q   <= cnt_q + 1'b1;
                    if (cnt_q == CntLast) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        d_q         <= res_nxt;
                        bout_q      <= ~carry_nxt;
                        zero_q      <= (res_nxt == '0);
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        state_q     <= StIdle;
                        out_valid_q <= 1'b0;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle) && !rst;
    assign bus.out_valid = out_valid_q;
    assign bus.D         = d_q;
    assign bus.Bout      = bout_q;
    assign bus.zero      = zero_q;
endmodule
